// File: rtl/bowling_scorer.sv
// rtl/bowling_scorer.sv - bowling scoring engine: pin snapshots in, frame scores and running totals out
module bowling_scorer #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_FRAMES  = 10,
    parameter int NUM_PINS    = 10,
    parameter int FRAME_W     = $clog2(3*NUM_PINS+1),
    parameter int SCORE_W     = $clog2(3*NUM_PINS*NUM_FRAMES+1),
    parameter int PLAYER_W    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    parameter int FRM_W       = $clog2(NUM_FRAMES),
    parameter int CNT_W       = $clog2(NUM_PINS+1)
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           valid_in,
    input  logic [NUM_PINS-1:0]            pin_hit,
    output logic [PLAYER_W-1:0]            player,
    output logic [FRM_W-1:0]               frame,
    output logic [1:0]                     roll,
    output logic [CNT_W-1:0]               roll_count_out,
    output logic                           roll_valid_out,
    output logic                           err_out,
    output logic                           rack_reset_out,
    output logic                           game_over,
    input  logic [PLAYER_W-1:0]            rd_player,
    input  logic [FRM_W-1:0]               rd_frame,
    output logic [FRAME_W-1:0]             rd_score,
    output logic                           rd_final,
    output logic [NUM_PLAYERS*SCORE_W-1:0] total_out
);

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } state_t;

    localparam logic [PLAYER_W-1:0] LAST_PLAYER = PLAYER_W'(NUM_PLAYERS-1);
    localparam logic [FRM_W-1:0]    LAST_FRAME  = FRM_W'(NUM_FRAMES-1);

    state_t                r_state, w_state_nxt;
    logic [NUM_PINS-1:0]   r_rack_down, w_rack_nxt;
    logic [PLAYER_W-1:0]   r_player, w_player_nxt;
    logic [FRM_W-1:0]      r_frame, w_frame_nxt;
    logic [1:0]            r_roll, w_roll_nxt;
    logic [FRAME_W-1:0]    r_score [NUM_PLAYERS][NUM_FRAMES];
    logic [FRAME_W-1:0]    w_score_nxt [NUM_PLAYERS][NUM_FRAMES];
    logic [1:0]            r_pend [NUM_PLAYERS][NUM_FRAMES];
    logic [1:0]            w_pend_nxt [NUM_PLAYERS][NUM_FRAMES];
    logic [SCORE_W-1:0]    r_total [NUM_PLAYERS];
    logic [SCORE_W-1:0]    w_total_nxt [NUM_PLAYERS];
    logic [CNT_W-1:0]      r_roll_count;
    logic                  r_roll_valid, r_err, r_rack_reset;
    logic [FRAME_W-1:0]    r_rd_score;
    logic                  r_rd_final;

    logic [NUM_PINS-1:0]   w_new;
    logic                  w_bad;
    logic [CNT_W-1:0]      w_n;
    logic [FRAME_W-1:0]    w_add;
    logic [FRAME_W-1:0]    w_sum;
    logic [SCORE_W-1:0]    w_tot_add;
    logic                  w_last;
    logic                  w_accept, w_err, w_rack_rst, w_frame_end;
    logic [FRM_W:0]        w_rd_cur_frame;
    logic                  w_rd_final;

    // Only pins still standing in the rack count; a pin reported up that was already down is illegal.
    always_comb begin
        w_new = pin_hit & ~r_rack_down;
        w_bad = |(~pin_hit & r_rack_down);
        w_n   = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            w_n = w_n + CNT_W'(w_new[i]);
        end
        w_add  = FRAME_W'(w_n);
        w_sum  = r_score[r_player][r_frame] + w_add;
        w_last = (r_frame == LAST_FRAME);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rack_nxt   = r_rack_down;
        w_player_nxt = r_player;
        w_frame_nxt  = r_frame;
        w_roll_nxt   = r_roll;
        w_score_nxt  = r_score;
        w_pend_nxt   = r_pend;
        w_total_nxt  = r_total;
        w_tot_add    = SCORE_W'(w_n);
        w_accept     = 1'b0;
        w_err        = 1'b0;
        w_rack_rst   = 1'b0;
        w_frame_end  = 1'b0;

        if (valid_in && r_state == ST_PLAY) begin
            if (w_bad) begin
                w_err = 1'b1;
            end else begin
                w_accept   = 1'b1;
                w_rack_nxt = pin_hit;
                for (int f = 0; f < NUM_FRAMES; f++) begin
                    if (r_pend[r_player][f] != 2'd0) begin
                        w_score_nxt[r_player][f] = r_score[r_player][f] + w_add;
                        w_pend_nxt[r_player][f]  = r_pend[r_player][f] - 2'd1;
                        w_tot_add                = w_tot_add + SCORE_W'(w_n);
                    end
                end
                w_score_nxt[r_player][r_frame] = w_sum;
                w_total_nxt[r_player]          = r_total[r_player] + w_tot_add;

                if (!w_last) begin
                    if (r_roll == 2'd0) begin
                        if (w_n == CNT_W'(NUM_PINS)) begin
                            w_pend_nxt[r_player][r_frame] = 2'd2;
                            w_frame_end                   = 1'b1;
                        end else begin
                            w_roll_nxt = 2'd1;
                        end
                    end else begin
                        if (w_sum == FRAME_W'(NUM_PINS)) begin
                            w_pend_nxt[r_player][r_frame] = 2'd1;
                        end
                        w_frame_end = 1'b1;
                    end
                end else begin
                    // Fill balls: the last frame only re-racks, it never leaves bonuses pending.
                    case (r_roll)
                        2'd0: begin
                            if (w_n == CNT_W'(NUM_PINS)) begin
                                w_rack_rst = 1'b1;
                                w_rack_nxt = '0;
                            end
                            w_roll_nxt = 2'd1;
                        end
                        2'd1: begin
                            if (w_sum >= FRAME_W'(NUM_PINS)) begin
                                w_rack_rst = 1'b1;
                                w_rack_nxt = '0;
                                w_roll_nxt = 2'd2;
                            end else begin
                                w_frame_end = 1'b1;
                            end
                        end
                        default: w_frame_end = 1'b1;
                    endcase
                end

                if (w_frame_end) begin
                    w_rack_rst = 1'b1;
                    w_rack_nxt = '0;
                    w_roll_nxt = 2'd0;
                    if (r_player == LAST_PLAYER) begin
                        w_player_nxt = '0;
                        if (w_last) begin
                            w_state_nxt = ST_OVER;
                        end else begin
                            w_frame_nxt = r_frame + 1'b1;
                        end
                    end else begin
                        w_player_nxt = r_player + 1'b1;
                    end
                end
            end
        end
    end

    // Players ahead of the bowler in rotation have already finished the bowler's frame.
    always_comb begin
        w_rd_cur_frame = {1'b0, w_frame_nxt} + (FRM_W+1)'(rd_player < w_player_nxt);
        w_rd_final     = (({1'b0, rd_frame} < w_rd_cur_frame) || (w_state_nxt == ST_OVER))
                         && (w_pend_nxt[rd_player][rd_frame] == 2'd0);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ST_PLAY;
            r_rack_down  <= '0;
            r_player     <= '0;
            r_frame      <= '0;
            r_roll       <= '0;
            r_roll_count <= '0;
            r_roll_valid <= 1'b0;
            r_err        <= 1'b0;
            r_rack_reset <= 1'b0;
            r_rd_score   <= '0;
            r_rd_final   <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_total[p] <= '0;
                for (int f = 0; f < NUM_FRAMES; f++) begin
                    r_score[p][f] <= '0;
                    r_pend[p][f]  <= '0;
                end
            end
        end else begin
            r_state      <= w_state_nxt;
            r_rack_down  <= w_rack_nxt;
            r_player     <= w_player_nxt;
            r_frame      <= w_frame_nxt;
            r_roll       <= w_roll_nxt;
            r_score      <= w_score_nxt;
            r_pend       <= w_pend_nxt;
            r_total      <= w_total_nxt;
            r_roll_valid <= w_accept;
            r_err        <= w_err;
            r_rack_reset <= w_rack_rst;
            r_rd_score   <= w_score_nxt[rd_player][rd_frame];
            r_rd_final   <= w_rd_final;
            if (w_accept) begin
                r_roll_count <= w_n;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            total_out[p*SCORE_W +: SCORE_W] = r_total[p];
        end
    end

    assign player         = r_player;
    assign frame          = r_frame;
    assign roll           = r_roll;
    assign roll_count_out = r_roll_count;
    assign roll_valid_out = r_roll_valid;
    assign err_out        = r_err;
    assign rack_reset_out = r_rack_reset;
    assign game_over      = (r_state == ST_OVER);
    assign rd_score       = r_rd_score;
    assign rd_final       = r_rd_final;

endmodule

// File: tb/tb_bowling_scorer.sv
// tb/tb_bowling_scorer.sv - directed bench: one-player and two-player scorer instances
module tb_bowling_scorer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // single-player instance
    logic       rst_a = 1'b0, va = 1'b0;
    logic [9:0] pa = '0;
    logic       rpa = 1'b0;
    logic [3:0] rfa = '0;
    logic       pl_a;
    logic [3:0] fr_a;
    logic [1:0] ro_a;
    logic [3:0] rc_a;
    logic       rv_a, er_a, rk_a, go_a, rdf_a;
    logic [4:0] rds_a;
    logic [8:0] tot_a;

    // two-player instance
    logic       rst_b = 1'b0, vb = 1'b0;
    logic [9:0] pb = '0;
    logic       rpb = 1'b0;
    logic [3:0] rfb = '0;
    logic       pl_b;
    logic [3:0] fr_b;
    logic [1:0] ro_b;
    logic [3:0] rc_b;
    logic       rv_b, er_b, rk_b, go_b, rdf_b;
    logic [4:0] rds_b;
    logic [17:0] tot_b;

    bowling_scorer #(.NUM_PLAYERS(1)) u_dut_a (
        .clk_in(clk), .rst_in(rst_a), .valid_in(va), .pin_hit(pa),
        .player(pl_a), .frame(fr_a), .roll(ro_a), .roll_count_out(rc_a),
        .roll_valid_out(rv_a), .err_out(er_a), .rack_reset_out(rk_a), .game_over(go_a),
        .rd_player(rpa), .rd_frame(rfa), .rd_score(rds_a), .rd_final(rdf_a), .total_out(tot_a)
    );

    bowling_scorer #(.NUM_PLAYERS(2)) u_dut_b (
        .clk_in(clk), .rst_in(rst_b), .valid_in(vb), .pin_hit(pb),
        .player(pl_b), .frame(fr_b), .roll(ro_b), .roll_count_out(rc_b),
        .roll_valid_out(rv_b), .err_out(er_b), .rack_reset_out(rk_b), .game_over(go_b),
        .rd_player(rpb), .rd_frame(rfb), .rd_score(rds_b), .rd_final(rdf_b), .total_out(tot_b)
    );

    task automatic reset_a();
        @(negedge clk); rst_a = 1'b1; va = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst_a = 1'b0;
    endtask

    task automatic reset_b();
        @(negedge clk); rst_b = 1'b1; vb = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst_b = 1'b0;
    endtask

    task automatic roll_a(input logic [9:0] ph);
        @(negedge clk); va = 1'b1; pa = ph;
        @(posedge clk); #1; va = 1'b0;
    endtask

    task automatic roll_b(input logic [9:0] ph);
        @(negedge clk); vb = 1'b1; pb = ph;
        @(posedge clk); #1; vb = 1'b0;
    endtask

    task automatic rd_a(input logic p, input logic [3:0] f);
        @(negedge clk); rpa = p; rfa = f;
        @(posedge clk); #1;
    endtask

    task automatic rd_b(input logic p, input logic [3:0] f);
        @(negedge clk); rpb = p; rfb = f;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_a();
        reset_b();
        n_vec++;
        if ({pl_a, fr_a, ro_a, rc_a, rv_a, er_a, rk_a, go_a, rds_a, rdf_a, tot_a} !== '0) begin
            n_err++; $display("FAIL reset_a: outputs got %h expected 0", {pl_a, fr_a, ro_a, rc_a, rv_a, er_a, rk_a, go_a, rds_a, rdf_a, tot_a});
        end
        n_vec++;
        if ({pl_b, fr_b, ro_b, rc_b, rv_b, er_b, rk_b, go_b, rds_b, rdf_b, tot_b} !== '0) begin
            n_err++; $display("FAIL reset_b: outputs got %h expected 0", {pl_b, fr_b, ro_b, rc_b, rv_b, er_b, rk_b, go_b, rds_b, rdf_b, tot_b});
        end
    endtask

    task automatic test_perfect_game();
        int racks = 0;
        reset_a();
        for (int i = 0; i < 12; i++) begin
            roll_a(10'h3FF);
            if (rk_a === 1'b1) racks++;
            n_vec++;
            if (rv_a !== 1'b1 || rc_a !== 4'd10) begin
                n_err++; $display("FAIL strike_roll%0d: valid=%b count=%0d expected valid=1 count=10", i, rv_a, rc_a);
            end
            n_vec++;
            if (go_a !== (i == 11)) begin
                n_err++; $display("FAIL strike_game_over%0d: got %b expected %b", i, go_a, (i == 11));
            end
        end
        n_vec++;
        if (racks != 12) begin
            n_err++; $display("FAIL strike_rack_resets: got %0d expected 12", racks);
        end
        for (int f = 0; f < 10; f++) begin
            rd_a(1'b0, 4'(f));
            n_vec++;
            if (rds_a !== 5'd30 || rdf_a !== 1'b1) begin
                n_err++; $display("FAIL strike_frame%0d: score=%0d final=%b expected 30 final=1", f, rds_a, rdf_a);
            end
        end
        n_vec++;
        if (tot_a !== 9'd300) begin
            n_err++; $display("FAIL strike_total: got %0d expected 300", tot_a);
        end
    endtask

    task automatic test_spares();
        reset_a();
        for (int f = 0; f < 9; f++) begin
            roll_a(10'h01F);
            roll_a(10'h3FF);
        end
        roll_a(10'h01F);
        roll_a(10'h3FF);
        n_vec++;
        if (ro_a !== 2'd2 || rk_a !== 1'b1 || go_a !== 1'b0) begin
            n_err++; $display("FAIL spare_fill: roll=%0d rack=%b over=%b expected roll=2 rack=1 over=0", ro_a, rk_a, go_a);
        end
        roll_a(10'h01F);
        n_vec++;
        if (go_a !== 1'b1 || rc_a !== 4'd5) begin
            n_err++; $display("FAIL spare_end: over=%b count=%0d expected over=1 count=5", go_a, rc_a);
        end
        for (int f = 0; f < 10; f++) begin
            rd_a(1'b0, 4'(f));
            n_vec++;
            if (rds_a !== 5'd15 || rdf_a !== 1'b1) begin
                n_err++; $display("FAIL spare_frame%0d: score=%0d final=%b expected 15 final=1", f, rds_a, rdf_a);
            end
        end
        n_vec++;
        if (tot_a !== 9'd150) begin
            n_err++; $display("FAIL spare_total: got %0d expected 150", tot_a);
        end
    endtask

    task automatic test_two_players();
        reset_b();
        roll_b(10'h3FF);
        n_vec++;
        if (pl_b !== 1'b1 || fr_b !== 4'd0 || ro_b !== 2'd0) begin
            n_err++; $display("FAIL two_p0_strike: player=%0d frame=%0d roll=%0d expected 1 0 0", pl_b, fr_b, ro_b);
        end
        roll_b(10'h007);
        n_vec++;
        if (pl_b !== 1'b1 || ro_b !== 2'd1 || rc_b !== 4'd3) begin
            n_err++; $display("FAIL two_p1_r0: player=%0d roll=%0d count=%0d expected 1 1 3", pl_b, ro_b, rc_b);
        end
        roll_b(10'h07F);
        n_vec++;
        if (pl_b !== 1'b0 || fr_b !== 4'd1 || rc_b !== 4'd4) begin
            n_err++; $display("FAIL two_p1_r1: player=%0d frame=%0d count=%0d expected 0 1 4", pl_b, fr_b, rc_b);
        end
        rd_b(1'b0, 4'd0);
        n_vec++;
        if (rds_b !== 5'd10 || rdf_b !== 1'b0) begin
            n_err++; $display("FAIL two_p0f0_pending: score=%0d final=%b expected 10 final=0", rds_b, rdf_b);
        end
        roll_b(10'h003);
        rd_b(1'b0, 4'd0);
        n_vec++;
        if (rds_b !== 5'd12 || rdf_b !== 1'b0) begin
            n_err++; $display("FAIL two_p0f0_half: score=%0d final=%b expected 12 final=0", rds_b, rdf_b);
        end
        roll_b(10'h07F);
        n_vec++;
        if (pl_b !== 1'b1 || rc_b !== 4'd5) begin
            n_err++; $display("FAIL two_p0_f1_end: player=%0d count=%0d expected 1 5", pl_b, rc_b);
        end
        rd_b(1'b0, 4'd0);
        n_vec++;
        if (rds_b !== 5'd17 || rdf_b !== 1'b1) begin
            n_err++; $display("FAIL two_p0f0_done: score=%0d final=%b expected 17 final=1", rds_b, rdf_b);
        end
        rd_b(1'b0, 4'd1);
        n_vec++;
        if (rds_b !== 5'd7 || rdf_b !== 1'b1) begin
            n_err++; $display("FAIL two_p0f1: score=%0d final=%b expected 7 final=1", rds_b, rdf_b);
        end
        n_vec++;
        if (tot_b[8:0] !== 9'd24 || tot_b[17:9] !== 9'd7) begin
            n_err++; $display("FAIL two_totals: p0=%0d p1=%0d expected 24 7", tot_b[8:0], tot_b[17:9]);
        end
    endtask

    task automatic test_reject();
        reset_b();
        roll_b(10'h003);
        n_vec++;
        if (rc_b !== 4'd2 || ro_b !== 2'd1) begin
            n_err++; $display("FAIL rej_first: count=%0d roll=%0d expected 2 1", rc_b, ro_b);
        end
        roll_b(10'h001);
        n_vec++;
        if (er_b !== 1'b1 || rv_b !== 1'b0 || ro_b !== 2'd1 || pl_b !== 1'b0 || rk_b !== 1'b0) begin
            n_err++; $display("FAIL rej_standup: err=%b valid=%b roll=%0d player=%0d rack=%b expected 1 0 1 0 0", er_b, rv_b, ro_b, pl_b, rk_b);
        end
        roll_b(10'h00F);
        n_vec++;
        if (er_b !== 1'b0 || rv_b !== 1'b1 || rc_b !== 4'd2 || pl_b !== 1'b1 || ro_b !== 2'd0) begin
            n_err++; $display("FAIL rej_recover: err=%b valid=%b count=%0d player=%0d roll=%0d expected 0 1 2 1 0", er_b, rv_b, rc_b, pl_b, ro_b);
        end
        rd_b(1'b0, 4'd0);
        n_vec++;
        if (rds_b !== 5'd4) begin
            n_err++; $display("FAIL rej_score: got %0d expected 4", rds_b);
        end
    endtask

    task automatic test_gutter();
        reset_a();
        for (int i = 0; i < 20; i++) begin
            roll_a(10'h000);
            n_vec++;
            if (go_a !== (i == 19) || rv_a !== 1'b1) begin
                n_err++; $display("FAIL gutter_roll%0d: over=%b valid=%b expected over=%b valid=1", i, go_a, rv_a, (i == 19));
            end
        end
        n_vec++;
        if (tot_a !== 9'd0) begin
            n_err++; $display("FAIL gutter_total: got %0d expected 0", tot_a);
        end
        roll_a(10'h3FF);
        n_vec++;
        if (rv_a !== 1'b0 || er_a !== 1'b0 || rk_a !== 1'b0 || tot_a !== 9'd0 || go_a !== 1'b1) begin
            n_err++; $display("FAIL gutter_after_over: valid=%b err=%b rack=%b total=%0d over=%b expected 0 0 0 0 1", rv_a, er_a, rk_a, tot_a, go_a);
        end
    endtask

    task automatic test_mid_reset();
        reset_a();
        for (int i = 0; i < 8; i++) roll_a(10'h000);
        roll_a(10'h007);
        n_vec++;
        if (fr_a !== 4'd4 || ro_a !== 2'd1) begin
            n_err++; $display("FAIL midrst_pre: frame=%0d roll=%0d expected 4 1", fr_a, ro_a);
        end
        @(negedge clk); rst_a = 1'b1; va = 1'b1; pa = 10'h3FF;
        @(posedge clk); #1; rst_a = 1'b0; va = 1'b0;
        n_vec++;
        if ({pl_a, fr_a, ro_a, rc_a, rv_a, er_a, rk_a, go_a, rds_a, rdf_a, tot_a} !== '0) begin
            n_err++; $display("FAIL midrst_clear: outputs got %h expected 0", {pl_a, fr_a, ro_a, rc_a, rv_a, er_a, rk_a, go_a, rds_a, rdf_a, tot_a});
        end
        roll_a(10'h3FF);
        n_vec++;
        if (rc_a !== 4'd10 || fr_a !== 4'd1 || tot_a !== 9'd10) begin
            n_err++; $display("FAIL midrst_next: count=%0d frame=%0d total=%0d expected 10 1 10", rc_a, fr_a, tot_a);
        end
        rd_a(1'b0, 4'd0);
        n_vec++;
        if (rds_a !== 5'd10 || rdf_a !== 1'b0) begin
            n_err++; $display("FAIL midrst_f0: score=%0d final=%b expected 10 final=0", rds_a, rdf_a);
        end
        rd_a(1'b0, 4'd4);
        n_vec++;
        if (rds_a !== 5'd0) begin
            n_err++; $display("FAIL midrst_f4: score=%0d expected 0", rds_a);
        end
    endtask

    initial begin
        test_reset();
        test_perfect_game();
        test_spares();
        test_two_players();
        test_reject();
        test_gutter();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
